alu_share_arbiter: RTL

//  Shares one 4-bit shift/add/sub datapath between two requesters (port 0, port 1).

---
 rtl/alu_share_arbiter_pkg.sv | 19 +
 rtl/alu_share_arbiter_alu4_core.sv | 26 ++
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: op encodings, width defaults
// and the result-slot state type.
package alu_share_arbiter_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_SH_W   = 2;
    localparam int DEF_CNT_W  = 8;

    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/alu_share_arbiter_alu4_core.sv
// Purely combinational shift/add/sub datapath shared by both requesters.
module alu4_core
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SH_W   = DEF_SH_W
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SH_W-1:0]   c,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_SRA:  result = $signed(a) >>> c;
            OP_SRL:  result = a >> c;
            OP_SUB:  result = a - b;
            OP_ADD:  result = a + b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a single
// registered result slot under response backpressure and a consumed-op counter.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SH_W   = DEF_SH_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_op0,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [SH_W-1:0]   req_c0,
    input  logic [1:0]        req_op1,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [SH_W-1:0]   req_c1,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready,
    output logic [CNT_W-1:0]  op_count
);

    slot_state_t       state_q;
    slot_state_t       state_d;
    logic              last_grant_q;
    logic              grant_sel;
    logic              free;
    logic              accept;
    logic              consume;
    logic [1:0]        sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [SH_W-1:0]   sel_c;
    logic [DATA_W-1:0] alu_result;

    assign rsp_valid = (state_q == FULL);
    assign consume   = rsp_valid & rsp_ready;

    // A consumer draining the slot this cycle frees it for a new accept, so
    // rsp_ready feeds req_ready combinationally to sustain one op per cycle.
    always_comb begin
        grant_sel = 1'b0;
        req_ready = 2'b00;
        free      = (state_q == EMPTY) | rsp_ready;
        if (req_valid == 2'b11) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = ~req_valid[0];
        end
        if (!reset && (req_valid != 2'b00) && free) begin
            req_ready = grant_sel ? 2'b10 : 2'b01;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (consume && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        sel_op = grant_sel ? req_op1 : req_op0;
        sel_a  = grant_sel ? req_a1  : req_a0;
        sel_b  = grant_sel ? req_b1  : req_b0;
        sel_c  = grant_sel ? req_c1  : req_c0;
    end

    alu4_core #(
        .DATA_W (DATA_W),
        .SH_W   (SH_W)
    ) u_alu (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .c      (sel_c),
        .result (alu_result)
    );

    // last_grant resets to port 1 so that port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data     <= '0;
            rsp_id       <= 1'b0;
            last_grant_q <= 1'b1;
            op_count     <= '0;
        end else begin
            if (accept) begin
                rsp_data     <= alu_result;
                rsp_id       <= grant_sel;
                last_grant_q <= grant_sel;
            end
            if (consume) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule
